lsu_ctrl: RTL

- Multi-cycle load/store initiator between the core's execute stage and the byte-addressed Data_Mem port (32-bit word accesses, combinational read, negedge-committed write).
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into memory read and write cycles.
- Performs read-modify-write for sub-word stores, and sign/zero extension for loads.
- Flags misaligned, out-of-range and illegal-funct3 requests.

---
 rtl/lsu_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : RV32I load/store initiator for a big-endian byte-addressed
//            memory; read-modify-write for SB/SH, sign/zero-extended loads.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int BUS_WIDTH = 32,
    parameter int MEM_BYTES = 2048
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_store,
    input  logic [2:0]           req_funct3,
    input  logic [BUS_WIDTH-1:0] req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    output logic                 resp_done,
    output logic                 resp_err,
    output logic [BUS_WIDTH-1:0] resp_rdata,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    output logic                 mem_wr_en,
    output logic                 mem_rd_en,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [BUS_WIDTH-1:0] c_addr_max = BUS_WIDTH'(MEM_BYTES - 4);
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_store;
    logic [2:0]             r_funct3;
    logic [BUS_WIDTH-1:0]   r_addr;
    logic [BUS_WIDTH-1:0]   r_wdata;
    logic [BUS_WIDTH-9:0]   r_merge;
    logic [BUS_WIDTH-1:0]   r_rdata;

    logic                   w_accept;
    logic                   w_f3_legal;
    logic                   w_misaligned;
    logic                   w_err;
    logic                   w_direct_write;
    logic [BUS_WIDTH-1:0]   w_load_ext;
    logic [BUS_WIDTH-1:0]   w_store_word;

    assign w_accept = req_valid && (r_state == S_IDLE);

    // Unsigned load encodings have no store counterpart.
    always_comb begin
        w_f3_legal = 1'b0;
        case (req_funct3)
            c_f3_b, c_f3_h, c_f3_w: w_f3_legal = 1'b1;
            c_f3_bu, c_f3_hu:       w_f3_legal = !req_store;
            default:                w_f3_legal = 1'b0;
        endcase
    end

    assign w_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_err          = !w_f3_legal || w_misaligned || (req_addr > c_addr_max);
    assign w_direct_write = req_store && (req_funct3 == c_f3_w);

    // Byte at the access address sits in the top lane of the word.
    always_comb begin
        w_load_ext = mem_rdata;
        case (r_funct3)
            c_f3_b:  w_load_ext = {{(BUS_WIDTH-8){mem_rdata[BUS_WIDTH-1]}},  mem_rdata[BUS_WIDTH-1 -: 8]};
            c_f3_bu: w_load_ext = {{(BUS_WIDTH-8){1'b0}},                    mem_rdata[BUS_WIDTH-1 -: 8]};
            c_f3_h:  w_load_ext = {{(BUS_WIDTH-16){mem_rdata[BUS_WIDTH-1]}}, mem_rdata[BUS_WIDTH-1 -: 16]};
            c_f3_hu: w_load_ext = {{(BUS_WIDTH-16){1'b0}},                   mem_rdata[BUS_WIDTH-1 -: 16]};
            default: w_load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        w_store_word = r_wdata;
        case (r_funct3[1:0])
            2'b00:   w_store_word = {r_wdata[7:0],  r_merge};
            2'b01:   w_store_word = {r_wdata[15:0], r_merge[BUS_WIDTH-17:0]};
            default: w_store_word = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (r_state == S_READ) begin
                if (r_store) begin
                    r_merge <= mem_rdata[BUS_WIDTH-9:0];
                end else begin
                    r_rdata <= w_load_ext;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        w_next = S_ERR;
                    end else if (w_direct_write) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ:  w_next = r_store ? S_WRITE : S_DONE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Enables are gated by rst so a reset during WRITE never reaches the
    // memory's negedge commit.
    assign req_ready  = (r_state == S_IDLE);
    assign resp_done  = (r_state == S_DONE) || (r_state == S_ERR);
    assign resp_err   = (r_state == S_ERR);
    assign resp_rdata = r_rdata;
    assign mem_rd_en  = (r_state == S_READ) && !rst;
    assign mem_wr_en  = (r_state == S_WRITE) && !rst;
    assign mem_addr   = ((r_state == S_READ) || (r_state == S_WRITE)) ? r_addr : '0;
    assign mem_wdata  = (r_state == S_WRITE) ? w_store_word : '0;

endmodule
`default_nettype wire
